asgn_expr_seq: RTL and testbench

//   Command-driven sequencer for a three-register (x, y, z) integer datapath.

---
 rtl/asgn_expr_seq_if.sv | 44 ++++
 rtl/asgn_expr_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_asgn_expr_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asgn_expr_seq_if.sv
// Command/response bundle for the asgn_expr_seq sequencer.
//
// Purpose:
//   Groups the command channel (opcode, register indices, immediate) and the
//   response channel (expression value, error flag) into one interface so the
//   command source and the sequencer connect with a single port each.
//
// Signals:
//   cmd_valid / cmd_ready   command handshake (master -> slave)
//   cmd_op   [3:0]          opcode
//   cmd_dst  [1:0]          target register index, 0=x 1=y 2=z 3=illegal
//   cmd_src  [1:0]          source register index for COPY
//   cmd_data [WIDTH-1:0]    immediate for LOAD
//   rsp_valid / rsp_ready   response handshake (slave -> master)
//   rsp_value [WIDTH-1:0]   expression value of the completed operation
//   rsp_err                 illegal opcode or register index
//
// Modports:
//   master  command source (bench or CPU-style master)
//   slave   the sequencer
interface asgn_expr_seq_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [1:0]       cmd_dst;
    logic [1:0]       cmd_src;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_value;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_value, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_value, rsp_err
    );
endinterface

// File: rtl/asgn_expr_seq.sv
// Command-driven sequencer for a three-register (x, y, z) integer datapath.
//
// Purpose:
//   Accepts one command at a time, executes a single assignment-expression
//   operation on the x/y/z registers (load, pre/post increment/decrement,
//   copy, or the chain z=y+1; y=z+1; x=y+1) and returns the expression value
//   on the response channel. All arithmetic wraps modulo 2**WIDTH.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   bus         command/response interface (slave side)
//   ox, oy, oz  current register values, registered and always visible
//
// Flow: IDLE accepts a command and latches its fields, EXEC runs for one
// cycle (three for CHAIN), RESP holds the response until it is consumed.
module asgn_expr_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    asgn_expr_seq_if.slave     bus,
    output logic [WIDTH-1:0]   ox,
    output logic [WIDTH-1:0]   oy,
    output logic [WIDTH-1:0]   oz
);

    localparam logic [3:0] OP_LOAD     = 4'd0;
    localparam logic [3:0] OP_POST_INC = 4'd1;
    localparam logic [3:0] OP_POST_DEC = 4'd2;
    localparam logic [3:0] OP_PRE_INC  = 4'd3;
    localparam logic [3:0] OP_PRE_DEC  = 4'd4;
    localparam logic [3:0] OP_COPY     = 4'd5;
    localparam logic [3:0] OP_CHAIN    = 4'd6;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       dst_q, dst_d;
    logic [1:0]       src_q, src_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] rsp_value_q, rsp_value_d;
    logic             rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0] dst_val;
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] wr_val;
    logic             wr_en;
    logic             legal;

    // State and datapath registers; reset abandons any operation in flight,
    // which also discards partial CHAIN writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            op_q        <= 4'd0;
            dst_q       <= 2'd0;
            src_q       <= 2'd0;
            data_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            rsp_value_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            data_q      <= data_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            rsp_value_q <= rsp_value_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and datapath logic for the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        op_d        = op_q;
        dst_d       = dst_q;
        src_d       = src_q;
        data_d      = data_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        rsp_value_d = rsp_value_q;
        rsp_err_d   = rsp_err_q;
        wr_en       = 1'b0;
        wr_val      = '0;

        case (dst_q)
            2'd0:    dst_val = x_q;
            2'd1:    dst_val = y_q;
            2'd2:    dst_val = z_q;
            default: dst_val = '0;
        endcase

        case (src_q)
            2'd0:    src_val = x_q;
            2'd1:    src_val = y_q;
            2'd2:    src_val = z_q;
            default: src_val = '0;
        endcase

        // CHAIN ignores dst/src; every other legal op needs a real dst, and
        // COPY additionally needs a real src.
        legal = (op_q == OP_CHAIN) ||
                ((op_q < OP_CHAIN) && (dst_q != 2'd3) &&
                 ((op_q != OP_COPY) || (src_q != 2'd3)));

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    dst_d   = bus.cmd_dst;
                    src_d   = bus.cmd_src;
                    data_d  = bus.cmd_data;
                    step_d  = 2'd0;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (!legal) begin
                    rsp_value_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else if (op_q == OP_CHAIN) begin
                    // One register per cycle so each step sees the value the
                    // previous step wrote.
                    case (step_q)
                        2'd0: begin
                            z_d    = y_q + ONE;
                            step_d = 2'd1;
                        end
                        2'd1: begin
                            y_d    = z_q + ONE;
                            step_d = 2'd2;
                        end
                        default: begin
                            x_d         = y_q + ONE;
                            rsp_value_d = y_q + ONE;
                            rsp_err_d   = 1'b0;
                            state_d     = RESP;
                        end
                    endcase
                end else begin
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                    wr_en     = 1'b1;
                    case (op_q)
                        OP_LOAD: begin
                            wr_val      = data_q;
                            rsp_value_d = data_q;
                        end
                        OP_POST_INC: begin
                            wr_val      = dst_val + ONE;
                            rsp_value_d = dst_val;
                        end
                        OP_POST_DEC: begin
                            wr_val      = dst_val - ONE;
                            rsp_value_d = dst_val;
                        end
                        OP_PRE_INC: begin
                            wr_val      = dst_val + ONE;
                            rsp_value_d = dst_val + ONE;
                        end
                        OP_PRE_DEC: begin
                            wr_val      = dst_val - ONE;
                            rsp_value_d = dst_val - ONE;
                        end
                        OP_COPY: begin
                            wr_val      = src_val;
                            rsp_value_d = src_val;
                        end
                        default: begin
                            wr_en       = 1'b0;
                            rsp_value_d = '0;
                        end
                    endcase
                    if (wr_en) begin
                        case (dst_q)
                            2'd0:    x_d = wr_val;
                            2'd1:    y_d = wr_val;
                            default: z_d = wr_val;
                        endcase
                    end
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // cmd_ready is gated by rst so nothing is offered while reset is held.
    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_value = rsp_value_q;
    assign bus.rsp_err   = rsp_err_q;
    assign ox            = x_q;
    assign oy            = y_q;
    assign oz            = z_q;

endmodule

// File: tb/tb_asgn_expr_seq.sv
// Self-checking bench for asgn_expr_seq.
//
// Purpose:
//   Drives the command/response interface as a master: a table of directed
//   vectors with hand-computed expectations, hand-written sequences for
//   backpressure and reset in the middle of CHAIN, and randomized commands
//   checked against a behavioural model of the x/y/z registers.
module tb_asgn_expr_seq;

    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] ox, oy, oz;

    asgn_expr_seq_if #(.WIDTH(WIDTH)) bus ();

    asgn_expr_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .ox  (ox),
        .oy  (oy),
        .oz  (oz)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference register file: index 0=x, 1=y, 2=z.
    logic [WIDTH-1:0] mreg [3];

    typedef struct {
        logic [3:0]       op;
        logic [1:0]       dst;
        logic [1:0]       src;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] exp_val;
        logic             exp_err;
        int               exp_lat;
        logic [WIDTH-1:0] exp_x;
        logic [WIDTH-1:0] exp_y;
        logic [WIDTH-1:0] exp_z;
    } vec_t;

    vec_t vecs[$];

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    // Behavioural model: applies one operation with plain sequential
    // semantics to the model registers.
    task automatic modelOp(input logic [3:0] op, input logic [1:0] dst,
                           input logic [1:0] src, input logic [WIDTH-1:0] data,
                           output logic [WIDTH-1:0] val, output logic err,
                           output int lat);
        val = '0;
        err = 1'b0;
        lat = (op == 4'd6) ? 3 : 1;
        if (op > 4'd6 || (op != 4'd6 && dst == 2'd3) || (op == 4'd5 && src == 2'd3)) begin
            err = 1'b1;
        end else begin
            case (op)
                4'd0: begin mreg[dst] = data; val = data; end
                4'd1: begin val = mreg[dst]; mreg[dst] = mreg[dst] + ONE; end
                4'd2: begin val = mreg[dst]; mreg[dst] = mreg[dst] - ONE; end
                4'd3: begin mreg[dst] = mreg[dst] + ONE; val = mreg[dst]; end
                4'd4: begin mreg[dst] = mreg[dst] - ONE; val = mreg[dst]; end
                4'd5: begin val = mreg[src]; mreg[dst] = mreg[src]; end
                default: begin
                    mreg[2] = mreg[1] + ONE;
                    mreg[1] = mreg[2] + ONE;
                    mreg[0] = mreg[1] + ONE;
                    val     = mreg[0];
                end
            endcase
        end
    endtask

    // Offers one command, waits for the response and samples it at the
    // falling edge where rsp_valid is first seen. Returns at that edge.
    task automatic sendCmd(input logic [3:0] op, input logic [1:0] dst,
                           input logic [1:0] src, input logic [WIDTH-1:0] data,
                           output logic [WIDTH-1:0] val, output logic err,
                           output int lat);
        int wait_cycles = 0;
        @(negedge clk);
        while (!bus.cmd_ready && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        checkOutput("cmd_ready_before_cmd", WIDTH'(bus.cmd_ready), ONE);
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src   = src;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.rsp_valid && lat < 10);
        val = bus.rsp_value;
        err = bus.rsp_err;
    endtask

    // Lets the pending response go and checks that rsp_valid drops.
    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rsp_valid_drop", WIDTH'(bus.rsp_valid), '0);
    endtask

    // Full transaction: command, response checks, optional stall, consume.
    task automatic applyStimulus(input string name, input logic [3:0] op,
                                 input logic [1:0] dst, input logic [1:0] src,
                                 input logic [WIDTH-1:0] data,
                                 input logic [WIDTH-1:0] exp_val, input logic exp_err,
                                 input int exp_lat, input logic [WIDTH-1:0] exp_x,
                                 input logic [WIDTH-1:0] exp_y,
                                 input logic [WIDTH-1:0] exp_z, input int stall);
        logic [WIDTH-1:0] val;
        logic             err;
        int               lat;
        bus.rsp_ready = (stall == 0);
        sendCmd(op, dst, src, data, val, err, lat);
        checkOutput({name, ".value"},   val, exp_val);
        checkOutput({name, ".err"},     WIDTH'(err), WIDTH'(exp_err));
        checkOutput({name, ".latency"}, WIDTH'(lat), WIDTH'(exp_lat));
        checkOutput({name, ".ox"}, ox, exp_x);
        checkOutput({name, ".oy"}, oy, exp_y);
        checkOutput({name, ".oz"}, oz, exp_z);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput({name, ".stall_value"}, bus.rsp_value, exp_val);
            checkOutput({name, ".stall_valid"}, WIDTH'(bus.rsp_valid), ONE);
        end
        consume();
    endtask

    // Global time limit so the bench always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] mval;
        logic             merr;
        int               mlat;
        logic [3:0]       rop;
        logic [1:0]       rdst, rsrc;
        logic [WIDTH-1:0] rdata;

        // op, dst, src, data, value, err, latency, x, y, z
        vecs.push_back('{4'd0,  2'd0, 2'd0, 32'd5,      32'd5,      1'b0, 1, 32'd5,  32'd0,  32'd0});
        vecs.push_back('{4'd1,  2'd0, 2'd0, 32'd0,      32'd5,      1'b0, 1, 32'd6,  32'd0,  32'd0});
        vecs.push_back('{4'd4,  2'd0, 2'd0, 32'd0,      32'd5,      1'b0, 1, 32'd5,  32'd0,  32'd0});
        vecs.push_back('{4'd2,  2'd2, 2'd0, 32'd0,      32'd0,      1'b0, 1, 32'd5,  32'd0,  ONES});
        vecs.push_back('{4'd3,  2'd2, 2'd0, 32'd0,      32'd0,      1'b0, 1, 32'd5,  32'd0,  32'd0});
        vecs.push_back('{4'd0,  2'd1, 2'd0, 32'd7,      32'd7,      1'b0, 1, 32'd5,  32'd7,  32'd0});
        vecs.push_back('{4'd6,  2'd3, 2'd3, 32'd0,      32'd10,     1'b0, 3, 32'd10, 32'd9,  32'd8});
        vecs.push_back('{4'd9,  2'd0, 2'd0, 32'd1234,   32'd0,      1'b1, 1, 32'd10, 32'd9,  32'd8});
        vecs.push_back('{4'd0,  2'd2, 2'd0, ONES,       ONES,       1'b0, 1, 32'd10, 32'd9,  ONES});
        vecs.push_back('{4'd3,  2'd2, 2'd0, 32'd0,      32'd0,      1'b0, 1, 32'd10, 32'd9,  32'd0});
        vecs.push_back('{4'd5,  2'd0, 2'd2, 32'd0,      32'd0,      1'b0, 1, 32'd0,  32'd9,  32'd0});
        vecs.push_back('{4'd5,  2'd1, 2'd1, 32'd0,      32'd9,      1'b0, 1, 32'd0,  32'd9,  32'd0});
        vecs.push_back('{4'd0,  2'd3, 2'd0, 32'd123,    32'd0,      1'b1, 1, 32'd0,  32'd9,  32'd0});
        vecs.push_back('{4'd5,  2'd2, 2'd3, 32'd0,      32'd0,      1'b1, 1, 32'd0,  32'd9,  32'd0});
        vecs.push_back('{4'd4,  2'd0, 2'd0, 32'd0,      ONES,       1'b0, 1, ONES,   32'd9,  32'd0});
        vecs.push_back('{4'd1,  2'd0, 2'd0, 32'd0,      ONES,       1'b0, 1, 32'd0,  32'd9,  32'd0});
        vecs.push_back('{4'd15, 2'd1, 2'd0, 32'd0,      32'd0,      1'b1, 1, 32'd0,  32'd9,  32'd0});
        vecs.push_back('{4'd6,  2'd0, 2'd0, 32'd0,      32'd12,     1'b0, 3, 32'd12, 32'd11, 32'd10});

        // Reset state, checked while rst is still held.
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_dst   = 2'd0;
        bus.cmd_src   = 2'd0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset.cmd_ready", WIDTH'(bus.cmd_ready), '0);
        checkOutput("reset.rsp_valid", WIDTH'(bus.rsp_valid), '0);
        checkOutput("reset.rsp_value", bus.rsp_value, '0);
        checkOutput("reset.rsp_err",   WIDTH'(bus.rsp_err), '0);
        checkOutput("reset.ox", ox, '0);
        checkOutput("reset.oy", oy, '0);
        checkOutput("reset.oz", oz, '0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset.cmd_ready", WIDTH'(bus.cmd_ready), ONE);

        // Directed vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].dst, vecs[i].src,
                          vecs[i].data, vecs[i].exp_val, vecs[i].exp_err, vecs[i].exp_lat,
                          vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_z, 0);
        end
        mreg[0] = 32'd12;
        mreg[1] = 32'd11;
        mreg[2] = 32'd10;

        // Backpressure: response held for 5 cycles while another command is
        // offered; that command must not be taken.
        bus.rsp_ready = 1'b0;
        sendCmd(4'd0, 2'd1, 2'd0, 32'd42, mval, merr, mlat);
        checkOutput("bp.value", mval, 32'd42);
        checkOutput("bp.latency", WIDTH'(mlat), ONE);
        bus.cmd_op    = 4'd0;
        bus.cmd_dst   = 2'd0;
        bus.cmd_data  = 32'd99;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp.rsp_valid", WIDTH'(bus.rsp_valid), ONE);
            checkOutput("bp.rsp_value", bus.rsp_value, 32'd42);
            checkOutput("bp.cmd_ready", WIDTH'(bus.cmd_ready), '0);
        end
        bus.cmd_valid = 1'b0;
        consume();
        repeat (2) @(negedge clk);
        checkOutput("bp.ox_untouched", ox, 32'd12);
        checkOutput("bp.oy", oy, 32'd42);
        mreg[1] = 32'd42;

        // Randomized commands against the model, with occasional stalls.
        for (int i = 0; i < 60; i++) begin
            rop   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 6));
            rdst  = 2'($urandom_range(0, 3));
            rsrc  = 2'($urandom_range(0, 3));
            rdata = ($urandom_range(0, 7) == 0) ? ONES : WIDTH'($urandom);
            modelOp(rop, rdst, rsrc, rdata, mval, merr, mlat);
            applyStimulus($sformatf("rand%0d", i), rop, rdst, rsrc, rdata, mval, merr,
                          mlat, mreg[0], mreg[1], mreg[2], int'($urandom_range(0, 2)));
        end

        // Reset during CHAIN step 1: step 0 has written z, then everything
        // is abandoned and cleared.
        @(negedge clk);
        checkOutput("rchain.cmd_ready", WIDTH'(bus.cmd_ready), ONE);
        bus.cmd_op    = 4'd6;
        bus.cmd_dst   = 2'd0;
        bus.cmd_src   = 2'd0;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rchain.step0_z", oz, mreg[1] + ONE);
        rst = 1'b1;
        #1;
        checkOutput("rchain.ox", ox, '0);
        checkOutput("rchain.oy", oy, '0);
        checkOutput("rchain.oz", oz, '0);
        checkOutput("rchain.rsp_valid", WIDTH'(bus.rsp_valid), '0);
        checkOutput("rchain.cmd_ready_in_reset", WIDTH'(bus.cmd_ready), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rchain.cmd_ready_after", WIDTH'(bus.cmd_ready), ONE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rchain.no_rsp", WIDTH'(bus.rsp_valid), '0);
        end
        mreg[0] = '0;
        mreg[1] = '0;
        mreg[2] = '0;

        // Sequencer still works after the abandoned op.
        modelOp(4'd0, 2'd0, 2'd0, 32'd3, mval, merr, mlat);
        applyStimulus("after_reset", 4'd0, 2'd0, 2'd0, 32'd3, mval, merr, mlat,
                      mreg[0], mreg[1], mreg[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
